// File: rtl/id_ex_pipe_reg_elastic.sv
// ID/EX elastic pipeline register: main + skid entry, fully registered outputs.
// Saturating back-pressure counter; flush inserts a bubble.
module id_ex_pipe_reg_elastic #(
    parameter int XLEN   = 32,
    parameter int RAW    = 5,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  logic [XLEN-1:0]   imm,
    input  logic [RAW-1:0]    rs1,
    input  logic [RAW-1:0]    rs2,
    input  logic [RAW-1:0]    rd,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic [CTRL_W-1:0] ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   pc_out,
    output logic [XLEN-1:0]   rs1_val_out,
    output logic [XLEN-1:0]   rs2_val_out,
    output logic [XLEN-1:0]   imm_out,
    output logic [RAW-1:0]    rs1_out,
    output logic [RAW-1:0]    rs2_out,
    output logic [RAW-1:0]    rd_out,
    output logic [2:0]        func3_out,
    output logic [6:0]        func7_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PW = 4*XLEN + 3*RAW + 10 + CTRL_W;

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    main_q, main_d;
    logic [PW-1:0]    skid_q, skid_d;
    logic [PW-1:0]    in_pl;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             xfer_in;

    assign in_pl = {pc, rs1_val, rs2_val, imm, rs1, rs2, rd,
                    func3, func7, ctrl};

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign stall_cnt = stall_q;
    assign xfer_in   = in_valid & in_ready_q;

    assign {pc_out, rs1_val_out, rs2_val_out, imm_out, rs1_out,
            rs2_out, rd_out, func3_out, func7_out, ctrl_out} = main_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (xfer_in) begin
                    main_d  = in_pl;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (out_ready) begin
                    if (xfer_in) main_d = in_pl;
                    else         state_d = EMPTY;
                end else if (xfer_in) begin
                    skid_d  = in_pl;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    main_d  = skid_q;
                    skid_d  = '0;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        // flush beats everything, leaving a zero-ctrl bubble behind
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end
    end

    assign in_ready_d = (state_d != FULL);

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && !flush && (stall_q != '1))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            stall_q    <= stall_d;
        end
    end

endmodule

// File: doc/id_ex_pipe_reg_elastic.md
ID_EX_PIPE_REG_ELASTIC -- requirements
Module: id_ex_pipe_reg_elastic

Interface
REQ-001 Parameter XLEN, default 32, operand/immediate/PC width.
REQ-002 Parameter RAW, default 5, register-address width.
REQ-003 Parameter CTRL_W, default 4, control-bundle width.
REQ-004 Parameter CNT_W, default 16, stall-counter width.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 flush  input  1  synchronous kill of all held and offered instructions.
REQ-008 in_valid  input  1  ID stage offers an instruction.
REQ-009 in_ready  output  1  block accepts an instruction this cycle.
REQ-010 pc, rs1_val, rs2_val, imm  input  XLEN each  ID payload.
REQ-011 rs1, rs2, rd  input  RAW each; func3 input 3; func7 input 7; ctrl input CTRL_W.
REQ-012 out_valid  output  1  EX-side instruction present.
REQ-013 out_ready  input  1  EX stage consumes the presented instruction.
REQ-014 pc_out, rs1_val_out, rs2_val_out, imm_out, rs1_out, rs2_out, rd_out, func3_out, func7_out, ctrl_out  output  same widths as inputs  registered payload.
REQ-015 stall_cnt  output  CNT_W  saturating count of back-pressured cycles.

Function
REQ-016 Storage SHALL be two payload registers: main (drives outputs) and skid; no combinational path from any input to any payload output.
REQ-017 in_ready SHALL be a registered signal equal to NOT skid_valid.
REQ-018 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-019 States SHALL be EMPTY (main/skid invalid), BUSY (main valid), FULL (both valid); out_valid=1 in BUSY and FULL.
REQ-020 EMPTY: in_valid -> load main, go BUSY; else stay.
REQ-021 BUSY: out_ready & in_valid -> reload main, stay BUSY; out_ready & !in_valid -> EMPTY; !out_ready & in_valid -> capture into skid, go FULL; neither -> hold.
REQ-022 FULL: out_ready -> main <= skid, go BUSY, in_ready rises next cycle; !out_ready -> hold; inputs ignored (in_ready=0).
REQ-023 Accept-to-present latency SHALL be exactly 1 cycle when EMPTY or BUSY with out_ready=1; zero-bubble throughput of 1 instr/cycle with out_ready held high.
REQ-024 Payload presented SHALL never change while out_valid=1 and out_ready=0.
REQ-025 Order SHALL be preserved: skid contents always older than any later accepted input.
REQ-026 flush=1 SHALL override all other inputs: next state EMPTY, main and skid payloads cleared to zero (ctrl_out=0 = bubble), in_ready=1 next cycle, same-cycle offered input discarded, same-cycle out transfer still counts as consumed by EX.
REQ-027 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0 and flush=0, saturating at 2^CNT_W-1; never wraps; cleared only by reset.

Reset
REQ-028 While rst=0, independent of clk: state EMPTY, out_valid=0, in_ready=0, all payload outputs 0, skid cleared, stall_cnt=0.
REQ-029 On first rising edge after rst deasserts, in_ready SHALL become 1; no instruction accepted before that edge.
REQ-030 Reset asserted mid-operation (BUSY/FULL) SHALL discard both entries immediately without requiring a clock.

Verification
REQ-031 Reset then stream rs1_val=AAAAAAAA, BBBBBBBB, CCCCCCCC with in_valid=1, out_ready=1 -> same values on rs1_val_out on consecutive cycles, 1-cycle latency, in_ready stays 1, stall_cnt=0.
REQ-032 BUSY holding imm=10, drop out_ready for 3 cycles while offering imm=40 -> imm_out stays 10, state FULL, in_ready=0 from cycle 2, stall_cnt=3; raise out_ready -> 10 then 40 delivered in order, nothing lost or duplicated.
REQ-033 FULL state, pulse flush with in_valid=1 and rd=7 -> next cycle out_valid=0, ctrl_out=0, rd_out=0, in_ready=1; rd=7 never appears.
REQ-034 Assert rst=0 between clock edges while FULL -> outputs and stall_cnt 0 immediately; after release, in_ready=1 only after first rising edge.
REQ-035 Hold out_ready=0 with out_valid=1 for 2^CNT_W+5 cycles (CNT_W=4 build) -> stall_cnt saturates at 15 and stays.
REQ-036 Random in_valid/out_ready/flush for 10k cycles against a FIFO scoreboard -> delivered sequence equals accepted sequence minus flushed entries; payload stable under back-pressure.
